// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART transmit path
//
// Purpose: frame FSM state encoding and the clocks-per-bit divisor helper
// used by the serializer top and its baud generator.
// Ports: none (package).

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Integer divisor; any remainder is dropped, so the real baud rate runs
  // slightly fast when CLK_FREQ is not an exact multiple of BAUD.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte request / serial line bundle for the UART transmitter
//
// Purpose: groups the request handshake from the ADC control FSM together
// with the transmitter status and line outputs.
// Ports (signals):
//   data_in    [7:0] byte offered for transmission (master -> slave)
//   new_data         single-cycle request strobe   (master -> slave)
//   tx_busy          frame in progress             (slave -> master)
//   tx               serial line, idle high        (slave -> master)
//   frame_done       last cycle of last stop bit   (slave -> master)

interface uart_tx_serializer_if;

  logic [7:0] data_in;
  logic       new_data;
  logic       tx_busy;
  logic       tx;
  logic       frame_done;

  modport master (
    output data_in,
    output new_data,
    input  tx_busy,
    input  tx,
    input  frame_done
  );

  modport slave (
    input  data_in,
    input  new_data,
    output tx_busy,
    output tx,
    output frame_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter for the UART transmitter
//
// Purpose: counts 0..CLKS_PER_BIT-1 while enabled and flags the final count
// of each bit period. Held at zero whenever en is low, so the first enabled
// cycle always starts a fresh bit period.
// Ports:
//   clk       system clock
//   reset     synchronous, active-high
//   en        count enable (frame in progress)
//   tick      high in the last cycle of a bit period
//   pre_tick  high in the second-to-last cycle of a bit period; lets the
//             parent load registered outputs that must line up with tick

module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick,
  output logic pre_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick     = en && (cnt_q == CNT_LAST);
  assign pre_tick = en && (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1/8N2 UART transmitter fed one byte per request strobe
//
// Purpose: accepts a byte when new_data is seen in IDLE and shifts it out
// LSB first as start bit, 8 data bits and STOP_BITS stop bits. Requests that
// arrive while a frame is in flight are dropped.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; aborts any frame in progress
//   bus    slave side of uart_tx_serializer_if
//            data_in/new_data in, tx/tx_busy/frame_done out (all registered)
// Parameters:
//   CLK_FREQ, BAUD  clock and line rate in Hz / bit/s; CLK_FREQ/BAUD >= 2
//   STOP_BITS       1 or 2

module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  bus
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic STOP_LAST  = 1'(STOP_BITS - 1);

  uart_state_t state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;
  logic        tx_busy_q, tx_busy_d;
  logic        frame_done_q, frame_done_d;

  logic        baud_en;
  logic        tick;
  logic        pre_tick;
  logic        last_stop;

  // Counter runs only while a frame is active, so entering START always
  // begins with a zeroed count.
  assign baud_en   = (state_q != IDLE);
  assign last_stop = (stop_cnt_q == STOP_LAST);

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (baud_en),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.new_data) begin
          state_d    = START;
          shift_d    = bus.data_in;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d    = STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (last_stop) begin
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so the registered line level
    // changes on the same edge as the state it belongs to.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    tx_busy_d = (state_d != IDLE);

    // Loaded one cycle early so the pulse lands in the final stop cycle.
    frame_done_d = (state_q == STOP) && last_stop && pre_tick;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= 8'h00;
      bit_idx_q    <= 3'd0;
      stop_cnt_q   <= 1'b0;
      tx_q         <= 1'b1;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      stop_cnt_q   <= stop_cnt_d;
      tx_q         <= tx_d;
      tx_busy_q    <= tx_busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - scoreboard bench for uart_tx_serializer (1 and 2 stop bits)

module tb_uart_tx_serializer;

  localparam int CPB = 8;

  typedef struct {
    logic [7:0] data;
    int         busy_len;
    int         fd_n;
  } exp_t;

  logic clk;
  logic reset;

  uart_tx_serializer_if b1();
  uart_tx_serializer_if b2();

  uart_tx_serializer #(.CLK_FREQ(8), .BAUD(1), .STOP_BITS(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  uart_tx_serializer #(.CLK_FREQ(8), .BAUD(1), .STOP_BITS(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  exp_t q1[$];
  exp_t q2[$];

  bit   in_frame[2];
  bit   have_exp[2];
  exp_t cur[2];
  int   c[2];
  int   fd_n[2];
  int   fd_pos[2];
  int   tx_err[2];
  int   first_bad[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level for 1-based cycle cyc of a frame carrying d.
  function automatic logic exp_level(input logic [7:0] d, input int cyc);
    int slot;
    slot = (cyc - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
    return 1'b1;
  endfunction

  task automatic mon_step(input int k, input logic busy, input logic txv, input logic fd);
    if (busy === 1'b1) begin
      if (!in_frame[k]) begin
        in_frame[k]  = 1'b1;
        c[k]         = 0;
        fd_n[k]      = 0;
        fd_pos[k]    = 0;
        tx_err[k]    = 0;
        first_bad[k] = 0;
        checks++;
        if ((k == 0 && q1.size() == 0) || (k == 1 && q2.size() == 0)) begin
          errors++;
          have_exp[k] = 1'b0;
          $display("FAIL unexpected_frame dut%0d: frame started with no expected entry", k + 1);
        end else begin
          if (k == 0) cur[k] = q1.pop_front();
          else        cur[k] = q2.pop_front();
          have_exp[k] = 1'b1;
        end
      end
      c[k]++;
      if (fd === 1'b1) begin
        fd_n[k]++;
        fd_pos[k] = c[k];
      end
      if (have_exp[k] && txv !== exp_level(cur[k].data, c[k])) begin
        if (tx_err[k] == 0) first_bad[k] = c[k];
        tx_err[k]++;
      end
    end else begin
      if (in_frame[k]) begin
        in_frame[k] = 1'b0;
        if (have_exp[k]) begin
          chk($sformatf("dut%0d_busy_len_%0h", k + 1, cur[k].data), c[k], cur[k].busy_len);
          chk($sformatf("dut%0d_fd_count_%0h", k + 1, cur[k].data), fd_n[k], cur[k].fd_n);
          if (cur[k].fd_n == 1)
            chk($sformatf("dut%0d_fd_pos_%0h", k + 1, cur[k].data), fd_pos[k], cur[k].busy_len);
          chk($sformatf("dut%0d_tx_bad_cycles_%0h(first %0d)", k + 1, cur[k].data, first_bad[k]),
              tx_err[k], 0);
        end
      end
      checks++;
      if (txv !== 1'b1 || fd !== 1'b0) begin
        errors++;
        $display("FAIL dut%0d_idle: tx=%b frame_done=%b expected tx=1 frame_done=0", k + 1, txv, fd);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_step(0, b1.tx_busy, b1.tx, b1.frame_done);
      mon_step(1, b2.tx_busy, b2.tx, b2.frame_done);
    end
  end

  task automatic send(input int k, input logic [7:0] d);
    @(negedge clk);
    if (k == 0) begin b1.data_in = d; b1.new_data = 1'b1; end
    else        begin b2.data_in = d; b2.new_data = 1'b1; end
    @(negedge clk);
    if (k == 0) b1.new_data = 1'b0;
    else        b2.new_data = 1'b0;
  endtask

  task automatic wait_busy(input int k, input logic lvl, input int max, output int n);
    logic b;
    n = 0;
    b = (k == 0) ? b1.tx_busy : b2.tx_busy;
    while (b !== lvl && n < max) begin
      @(negedge clk);
      n++;
      b = (k == 0) ? b1.tx_busy : b2.tx_busy;
    end
    if (b !== lvl) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: tx_busy=%b expected %b within %0d cycles", k + 1, b, lvl, max);
    end
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    b1.data_in  = 8'h00;
    b1.new_data = 1'b0;
    b2.data_in  = 8'h00;
    b2.new_data = 1'b0;

    // 1: reset state, then idle with no request
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx1", b1.tx, 1'b1);
    chk("rst_busy1", b1.tx_busy, 1'b0);
    chk("rst_fd1", b1.frame_done, 1'b0);
    chk("rst_tx2", b2.tx, 1'b1);
    chk("rst_busy2", b2.tx_busy, 1'b0);
    chk("rst_fd2", b2.frame_done, 1'b0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // 2: single 8'hA5 frame: 0,1,0,1,0,0,1,0,1,1 for 8 cycles each
    q1.push_back('{8'hA5, 80, 1});
    send(0, 8'hA5);
    wait_busy(0, 1'b0, 200, n);
    repeat (3) @(negedge clk);

    // 3: 8'h00 request at cycle 20 of an 8'h3C frame is dropped
    q1.push_back('{8'h3C, 80, 1});
    send(0, 8'h3C);
    repeat (19) @(negedge clk);
    b1.data_in  = 8'h00;
    b1.new_data = 1'b1;
    @(negedge clk);
    b1.new_data = 1'b0;
    wait_busy(0, 1'b0, 200, n);
    repeat (5) @(negedge clk);

    // 4: new_data held high: frames separated by exactly one idle cycle
    repeat (3) q1.push_back('{8'hFF, 80, 1});
    b1.data_in  = 8'hFF;
    b1.new_data = 1'b1;
    wait_busy(0, 1'b1, 20, n);
    wait_busy(0, 1'b0, 200, n);
    wait_busy(0, 1'b1, 20, n);
    chk("gap1_low_cycles", n, 1);
    wait_busy(0, 1'b0, 200, n);
    wait_busy(0, 1'b1, 20, n);
    chk("gap2_low_cycles", n, 1);
    b1.new_data = 1'b0;
    wait_busy(0, 1'b0, 200, n);
    repeat (5) @(negedge clk);

    // 5: two stop bits, 8'h81: 16-cycle stop level, 88 busy cycles
    q2.push_back('{8'h81, 88, 1});
    send(1, 8'h81);
    wait_busy(1, 1'b0, 200, n);
    repeat (5) @(negedge clk);

    // 6: reset at cycle 30 of a frame, then a clean 8'h5A frame
    q1.push_back('{8'h5A, 30, 0});
    send(0, 8'h5A);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx", b1.tx, 1'b1);
    chk("abort_busy", b1.tx_busy, 1'b0);
    chk("abort_fd", b1.frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    q1.push_back('{8'h5A, 80, 1});
    send(0, 8'h5A);
    wait_busy(0, 1'b0, 200, n);
    repeat (5) @(negedge clk);

    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Byte-wide UART transmitter consuming the 8-bit samples produced by the ADC logging control FSM. Accepts one byte per `new_data` strobe and serializes it as 8N1 (or 8N2) frames on a single TX pin toward the host. Reports `tx_busy` back to the control FSM so it never offers a byte mid-frame. Sits between the ADC control FSM and the board's UART TX pin.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115_200, line rate in bits/s
- `STOP_BITS`, 1, number of stop bits; legal values are 1 or 2
- `CLKS_PER_BIT`, CLK_FREQ/BAUD (integer division, 434 by default), derived localparam; must be ≥ 2
---
- `clk`  input  1  system clock; all logic is on its rising edge
- `reset`  input  1  synchronous, active-high reset
- `data_in`  input  8  byte to transmit; sampled only on acceptance
- `new_data`  input  1  single-cycle request strobe from the control FSM
- `tx_busy`  output  1  high from the cycle after acceptance to the end of the last stop bit
- `tx`  output  1  serial line; idle high
- `frame_done`  output  1  one-cycle pulse in the final cycle of the last stop bit

## Operation
- States: IDLE, START, DATA, STOP.
- **IDLE:** `tx`=1, `tx_busy`=0. Acceptance occurs when `new_data`=1 in IDLE. On acceptance:
  - latch `data_in` into the shift register
  - clear the baud counter
  - go to START
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:** `tx` = shift register bit 0, i.e. LSB first. Each bit lasts CLKS_PER_BIT cycles, then the register shifts right and the bit index increments. After bit 7 (index 7 expires), go to STOP.
- **STOP:** `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. `frame_done` pulses in the last of these cycles, then the FSM returns to IDLE.
- `new_data` outside IDLE is ignored: no queueing, no error flag. The control FSM is responsible for waiting on `tx_busy`.
- **Baud counter:** width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, wraps to 0, and emits a bit-tick on the CLKS_PER_BIT-1 count. The counter is held at 0 in IDLE.
- **Bit index:** 3 bits, counts 0..7 with no wrap beyond 7. The stop-bit counter is 1 bit.
- **Reset values:** `tx`=1, `tx_busy`=0, `frame_done`=0, state IDLE, all counters 0, shift register 0.
- **Reset mid-frame:** the frame is aborted, `tx` returns to 1 on the next edge, and the byte is discarded.

## Timing
- `tx`, `tx_busy` and `frame_done` are registered outputs; none of them is combinational from the inputs.
- **Acceptance at edge N:** `tx` falls and `tx_busy` rises at edge N, and both are visible during cycle N+1.
- **Frame length:** `tx_busy` stays high for exactly CLKS_PER_BIT×(9+STOP_BITS) cycles.
- **Back-to-back frames:** `tx_busy` is low for at least one cycle between frames. A `new_data` in that first low cycle is accepted, giving a minimum inter-frame gap of 1 clock of idle-high beyond the stop bits.
- `new_data` coincident with `reset`: reset wins and nothing is accepted.

## Structure
- Package `uart_pkg`:
  - `uart_state_t` enum {IDLE, START, DATA, STOP}
  - constant function `clks_per_bit(freq, baud)`
- Sub-module `uart_baud_gen` holds the baud counter. Its interface is `clk`, `reset`, `en` → `tick`. It is cleared whenever `en` is low.
- The top level contains the FSM, shift register, bit index and stop counter. The design targets roughly 150–200 lines total.

## Test plan
Scenarios 1–4 use CLK_FREQ=8 and BAUD=1, giving CLKS_PER_BIT=8.
1. Reset held 3 cycles, then released with no request → `tx`=1, `tx_busy`=0, `frame_done`=0 throughout.
2. Send `data_in`=8'hA5 with a `new_data` pulse → `tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 8 cycles. `tx_busy` is high for 80 cycles and `frame_done` pulses once, in cycle 80.
3. `new_data` pulses with 8'h00 at cycle 20 of a frame carrying 8'h3C → the 8'h3C frame is unchanged and the 8'h00 is never transmitted.
4. Hold `new_data` high continuously with 8'hFF → consecutive frames separated by exactly 1 idle-high cycle. `tx_busy` is low for exactly 1 cycle between frames.
5. STOP_BITS=2, send 8'h81 → stop level lasts 16 cycles and `tx_busy` is high for 88 cycles.
6. Assert `reset` at cycle 30 of a frame → `tx`=1 and `tx_busy`=0 on the next edge. A following 8'h5A request produces a clean, complete frame.
